mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multiply/divide unit for the E stage of the five-stage MIPS pipeline: it executes mult, multu, div, divu, mthi and mtlo, and holds the architectural HI/LO registers. It produces the `start` and `busy` signals that the hazard unit uses to stall md-class instructions in D. It also supplies HI/LO to the E-stage result mux for mfhi/mflo.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: busy duration of mult/multu.
- `DIV_CYCLES`, default 10: busy duration of div/divu.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; 0 at a rising edge resets the block.
- `E_A`  in  32  forwarded rs operand in E.
- `E_B`  in  32  forwarded rt operand in E.
- `E_mdop`  in  3  E-stage operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none.
- `start`  out  1  combinational; 1 when `E_mdop` is 1–4 and `busy`=0.
- `busy`  out  1  registered; 1 while an operation is in flight.
- `HI`  out  32  registered HI.
- `LO`  out  32  registered LO.

## Operation

- Reset (`reset`=0 at an edge) clears `busy`, the counter, HI, LO and the pending result. Outputs after reset: `busy`=0, HI=0, LO=0, `start` follows `E_mdop`.
- Reset mid-operation abandons the operation. HI/LO are never written by it.

States:
- IDLE (`busy`=0):
  - On an edge with `start`=1, compute the 64-bit result from `E_A`/`E_B` into an internal pending register.
  - On the same edge, load the counter with `MULT_CYCLES` or `DIV_CYCLES`, set `busy`=1 and go to RUN.
- RUN (`busy`=1):
  - Decrement the counter each edge.
  - On the edge where the counter is 1, write the pending result to HI/LO, clear `busy` and go to IDLE.

Arithmetic rules:
- mult: signed 32×32 → 64. HI = product[63:32], LO = product[31:0].
- multu: the same, unsigned.
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- div overflow case 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- divu: unsigned quotient and remainder.
- Divisor zero (div/divu): the full busy period still runs; HI/LO keep their old values at completion.

mthi/mtlo:
- When `busy`=0, HI (mthi) or LO (mtlo) takes `E_A` at the edge, with no busy period.
- When `busy`=1, they are ignored. The hazard unit guarantees they never reach E while busy.

Other rules:
- Any `E_mdop` 1–6 arriving while `busy`=1 is ignored. The in-flight operation is not disturbed and `start` stays 0.
- There is no flush input. A stall bubble in E presents `E_mdop`=0.

## Timing

- Operation issued in cycle T: `start`=1 in T.
- `busy`=1 in cycles T+1 … T+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- HI/LO hold the new value and `busy`=0 from cycle T+N+1.
- A back-to-back md op may issue in T+N+1 and raise `start` that cycle.
- mthi/mtlo in cycle T: the new HI/LO is visible in T+1.
- mfhi/mflo read `HI`/`LO` directly. The hazard unit stalls them in D while `start`|`busy`, so no bypass from the pending register is needed.
- The counter is 4 bits wide. Both parameters must be in the range 1–15.

## Test plan

- Reset, then mult with E_A=0xFFFFFFFE (−2), E_B=3:
  - `start`=1 in T, `busy`=1 for T+1…T+5.
  - From T+6: HI=0xFFFFFFFF, LO=0xFFFFFFFA, `busy`=0.
- multu with 0xFFFFFFFF × 0xFFFFFFFF:
  - HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- div −7 / 2:
  - `busy` for 10 cycles.
  - Then LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - divu 7/2 then gives LO=3, HI=1.
- div by zero with prior HI=0x11, LO=0x22:
  - `busy` for 10 cycles.
  - HI=0x11, LO=0x22 are unchanged afterwards.
- During busy, drive `E_mdop`=mult and `E_mdop`=mthi with E_A=0x55:
  - `start`=0 throughout.
  - The original result lands on schedule and HI≠0x55.
  - mthi 0x55 when idle gives HI=0x55 the next cycle.
- Drive `reset`=0 at cycle T+3 of a div:
  - Next cycle `busy`=0, HI=LO=0.
  - No later write occurs.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage MIPS multiply/divide unit with HI/LO registers and a fixed busy period
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic [2:0]  E_mdop,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  logic [3:0]  cnt;
  logic [63:0] pend;
  logic        pend_wr;
  logic        is_mul, is_div, sgn, neg_a, neg_b, b_zero;
  logic [63:0] prod, res;
  logic [31:0] abs_a, abs_b, uq, ur, q, r;
  always_comb begin
    is_mul = (E_mdop == OP_MULT) || (E_mdop == OP_MULTU);
    is_div = (E_mdop == OP_DIV) || (E_mdop == OP_DIVU);
    start  = (is_mul || is_div) && !busy;
    sgn    = (E_mdop == OP_MULT) || (E_mdop == OP_DIV);
    neg_a  = sgn && E_A[31];
    neg_b  = sgn && E_B[31];
    b_zero = (E_B == 32'd0);
    prod   = {{32{neg_a}}, E_A} * {{32{neg_b}}, E_B};
    abs_a  = neg_a ? -E_A : E_A;
    abs_b  = neg_b ? -E_B : E_B;
    uq     = b_zero ? 32'd0 : abs_a / abs_b;
    ur     = b_zero ? 32'd0 : abs_a % abs_b;
    q      = (neg_a ^ neg_b) ? -uq : uq;
    r      = neg_a ? -ur : ur;
    res    = is_div ? {r, q} : prod;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy    <= 1'b0;
      cnt     <= 4'd0;
      HI      <= 32'd0;
      LO      <= 32'd0;
      pend    <= 64'd0;
      pend_wr <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        busy <= 1'b0;
        if (pend_wr) {HI, LO} <= pend;
      end
    end else if (start) begin
      pend    <= res;
      pend_wr <= !(is_div && b_zero);
      cnt     <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      busy    <= 1'b1;
    end else if (E_mdop == OP_MTHI) begin
      HI <= E_A;
    end else if (E_mdop == OP_MTLO) begin
      LO <= E_A;
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] E_A, E_B;
  logic [2:0]  E_mdop;
  logic        start, busy;
  logic [31:0] HI, LO;
  int pass_cnt = 0;
  int total = 0;
  logic [31:0] exp_hi, exp_lo;
  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_A(E_A), .E_B(E_B), .E_mdop(E_mdop),
    .start(start), .busy(busy), .HI(HI), .LO(LO)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s: got %h expected %h", name, act, req);
    else pass_cnt++;
  endtask
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, output bit wr);
    longint p;
    longint unsigned pu;
    int q, r;
    wr = 1'b1;
    case (op)
      3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p; end
      3'd2: begin pu = longint'({32'd0, a}) * longint'({32'd0, b}); return pu; end
      3'd3: begin
        if (b == 0) begin wr = 1'b0; return 64'd0; end
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 0) begin wr = 1'b0; return 64'd0; end
        return {a % b, a / b};
      end
    endcase
  endfunction
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit noise);
    int n;
    bit wr;
    logic [63:0] r;
    n = (op >= 3'd3) ? 10 : 5;
    r = ref_md(op, a, b, wr);
    E_A = a; E_B = b; E_mdop = op;
    #1;
    chk({name, " start"}, 32'(start), 32'd1);
    tick();
    for (int i = 0; i < n; i++) begin
      if (noise) begin
        E_mdop = 3'($urandom_range(1, 6));
        E_A = 32'h55; E_B = $urandom;
        #1;
        chk({name, " start_busy"}, 32'(start), 32'd0);
      end else begin
        E_mdop = 3'd0;
      end
      chk({name, " busy"}, 32'(busy), 32'd1);
      tick();
    end
    E_mdop = 3'd0;
    if (wr) {exp_hi, exp_lo} = r;
    #1;
    chk({name, " done"}, 32'(busy), 32'd0);
    chk({name, " HI"}, HI, exp_hi);
    chk({name, " LO"}, LO, exp_lo);
  endtask
  task automatic mt(input bit hi, input logic [31:0] v);
    E_mdop = hi ? 3'd5 : 3'd6; E_A = v;
    #1;
    chk("mt start", 32'(start), 32'd0);
    tick();
    E_mdop = 3'd0;
    if (hi) exp_hi = v; else exp_lo = v;
    chk("mt HI", HI, exp_hi);
    chk("mt LO", LO, exp_lo);
  endtask
  task automatic test_reset();
    reset = 1'b0; E_mdop = 3'd0; E_A = 0; E_B = 0;
    tick(); tick();
    exp_hi = 0; exp_lo = 0;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    E_mdop = 3'd1;
    #1;
    chk("reset start", 32'(start), 32'd1);
    E_mdop = 3'd7;
    #1;
    chk("reset start7", 32'(start), 32'd0);
    E_mdop = 3'd0;
    reset = 1'b1;
    tick();
  endtask
  task automatic test_directed();
    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult HI const", HI, 32'hFFFF_FFFF);
    chk("mult LO const", LO, 32'hFFFF_FFFA);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu HI const", HI, 32'hFFFF_FFFE);
    chk("multu LO const", LO, 32'h0000_0001);
    run_op("div", 3'd3, -32'sd7, 32'd2, 1'b0);
    chk("div LO const", LO, 32'hFFFF_FFFD);
    chk("div HI const", HI, 32'hFFFF_FFFF);
    run_op("divu", 3'd4, 32'd7, 32'd2, 1'b0);
    chk("divu LO const", LO, 32'd3);
    chk("divu HI const", HI, 32'd1);
    run_op("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("ovf LO const", LO, 32'h8000_0000);
    chk("ovf HI const", HI, 32'd0);
    mt(1'b1, 32'h11);
    mt(1'b0, 32'h22);
    run_op("div0", 3'd3, 32'd99, 32'd0, 1'b0);
    chk("div0 HI const", HI, 32'h11);
    chk("div0 LO const", LO, 32'h22);
    run_op("divu0", 3'd4, 32'd99, 32'd0, 1'b0);
  endtask
  task automatic test_busy_ignore();
    run_op("ignore", 3'd1, 32'd1000, 32'd7, 1'b1);
    total++;
    if (HI === 32'h55) $display("FAIL ignore HI: got %h, must differ from 00000055", HI);
    else pass_cnt++;
    mt(1'b1, 32'h55);
    chk("mthi idle", HI, 32'h55);
  endtask
  task automatic test_reset_mid();
    E_A = -32'sd100; E_B = 32'd3; E_mdop = 3'd3;
    tick();
    E_mdop = 3'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_hi = 0; exp_lo = 0;
    chk("rmid busy", 32'(busy), 32'd0);
    chk("rmid HI", HI, 32'd0);
    chk("rmid LO", LO, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("rmid late busy", 32'(busy), 32'd0);
    chk("rmid late HI", HI, 32'd0);
    chk("rmid late LO", LO, 32'd0);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  task automatic test_back_to_back();
    logic [2:0] op;
    for (int k = 0; k < 60; k++) begin
      op = 3'($urandom_range(1, 6));
      if (op >= 3'd5) mt(op == 3'd5, pick());
      else run_op("rand", op, pick(), pick(), 1'($urandom_range(0, 1)));
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
